// File: rtl/clk_period_meas_if.sv
// Measurement bundle for clk_period_meas.
// The slave modport is the measuring block. It samples clk_i and drives the results.
// The master modport is whoever supplies the waveform and consumes the results.
//   clk_i       measured square wave, asynchronous to the system clock
//   cnt_to_o    last accepted half-period in system clock cycles
//   meas_vld_o  one-cycle pulse whenever cnt_to_o is refreshed
//   locked_o    consecutive measurements agree within tolerance
interface clk_period_meas_if #(
    parameter int CNT_W = 21
) ();
    logic             clk_i;
    logic [CNT_W-1:0] cnt_to_o;
    logic             meas_vld_o;
    logic             locked_o;

    modport master (
        output clk_i,
        input  cnt_to_o,
        input  meas_vld_o,
        input  locked_o
    );

    modport slave (
        input  clk_i,
        output cnt_to_o,
        output meas_vld_o,
        output locked_o
    );
endinterface

// File: rtl/clk_period_meas.sv
// Half-period meter for a slow square wave, such as the link-rate divided clock.
// Both edges of clk_i restart an interval counter. The count reached at each
// edge is the recovered cnt_to value. Lock is declared after LOCK_N consecutive
// measurement pairs agree within TOL cycles.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low
//   io     clk_period_meas_if.slave (clk_i in; cnt_to_o, meas_vld_o, locked_o out)
module clk_period_meas #(
    parameter int CNT_W  = 21,
    parameter int TOL    = 2,
    parameter int LOCK_N = 4
) (
    input  logic                clk,
    input  logic                reset,
    clk_period_meas_if.slave    io
);
    typedef enum logic [1:0] {IDLE, ARMED, TRACK, LOCKED} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam int               MW       = $clog2(LOCK_N + 1);
    localparam logic [MW-1:0]    LOCK_CNT = MW'(LOCK_N);

    logic             r_s1, r_s2, r_s3;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_prev;
    logic [CNT_W-1:0] r_cntTo;
    logic             r_measVld;
    logic             r_locked;
    logic [MW-1:0]    r_matchCnt;
    state_t           r_state;

    logic             w_edge;
    logic             w_timeout;
    logic [CNT_W:0]   w_diff;
    logic [CNT_W:0]   w_absDiff;
    logic             w_inTol;
    logic             w_accept;
    logic [MW-1:0]    w_nextMatch;
    state_t           w_nextState;

    // Two flops of metastability filtering, plus a history flop for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= io.clk_i;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_edge = r_s2 ^ r_s3;

    // The interval counter restarts at 1 on every edge.
    // Edges N cycles apart therefore sample exactly N.
    // The counter saturates so that a dead input is recognisable as a timeout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_edge) begin
            r_cnt <= CNT_W'(1);
        end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // An edge arriving in the saturation cycle wins, so a timeout only fires with no edge.
    assign w_timeout = (r_cnt == CNT_MAX) && !w_edge;

    // The difference is taken one bit wider so it never wraps.
    assign w_diff    = {1'b0, r_cnt} - {1'b0, r_prev};
    assign w_absDiff = w_diff[CNT_W] ? (~w_diff + (CNT_W+1)'(1)) : w_diff;
    assign w_inTol   = (w_absDiff <= (CNT_W+1)'(TOL));

    // Next-state logic. ARMED only produces a first sample with no predecessor.
    // TRACK and LOCKED both compare against the previous sample.
    always_comb begin
        w_nextState = r_state;
        w_nextMatch = r_matchCnt;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_edge) begin
                    w_nextState = ARMED;
                end
            end
            ARMED: begin
                if (w_edge) begin
                    w_accept    = 1'b1;
                    w_nextMatch = '0;
                    w_nextState = TRACK;
                end else if (w_timeout) begin
                    w_nextMatch = '0;
                    w_nextState = IDLE;
                end
            end
            TRACK, LOCKED: begin
                if (w_edge) begin
                    w_accept = 1'b1;
                    if (w_inTol) begin
                        w_nextMatch = (r_matchCnt == LOCK_CNT) ? LOCK_CNT
                                                               : r_matchCnt + MW'(1);
                        if (w_nextMatch == LOCK_CNT) begin
                            w_nextState = LOCKED;
                        end
                    end else begin
                        w_nextMatch = '0;
                        w_nextState = TRACK;
                    end
                end else if (w_timeout) begin
                    w_nextMatch = '0;
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextMatch = '0;
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_matchCnt <= '0;
        end else begin
            r_state    <= w_nextState;
            r_matchCnt <= w_nextMatch;
        end
    end

    // locked_o follows the next state.
    // It therefore changes in the same cycle as the meas_vld_o pulse that caused the change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cntTo   <= '0;
            r_prev    <= '0;
            r_measVld <= 1'b0;
            r_locked  <= 1'b0;
        end else begin
            r_measVld <= w_accept;
            r_locked  <= (w_nextState == LOCKED);
            if (w_accept) begin
                r_cntTo <= r_cnt;
                r_prev  <= r_cnt;
            end
        end
    end

    assign io.cnt_to_o   = r_cntTo;
    assign io.meas_vld_o = r_measVld;
    assign io.locked_o   = r_locked;
endmodule

// File: tb/tb_clk_period_meas.sv
// Testbench for clk_period_meas.
// clk_i is toggled on the falling edge of clk, so every interval is an exact number of cycles.
// Each toggle that should produce a measurement pushes the hand-computed cnt_to_o and locked_o.
// A monitor pops one entry for every meas_vld_o pulse.
// Ports: none (top-level bench).
module tb_clk_period_meas;
    localparam int CNT_W  = 8;
    localparam int TOL    = 2;
    localparam int LOCK_N = 4;

    typedef struct {
        int cnt;
        bit lock;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    exp_t expQ[$];

    clk_period_meas_if #(.CNT_W(CNT_W)) measIf ();

    clk_period_meas #(
        .CNT_W  (CNT_W),
        .TOL    (TOL),
        .LOCK_N (LOCK_N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .io    (measIf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Wait n cycles, toggle clk_i, and record the expected measurement if this edge should produce one.
    task automatic applyStimulus(input int n, input bit expVld, input int expCnt, input bit expLock);
        exp_t item;
        repeat (n) @(negedge clk);
        measIf.clk_i = ~measIf.clk_i;
        if (expVld) begin
            item.cnt  = expCnt;
            item.lock = expLock;
            expQ.push_back(item);
        end
    endtask

    // Every meas_vld_o pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (measIf.meas_vld_o === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_meas_vld actual=1 expected=0 cnt_to=%0d at %0t",
                         measIf.cnt_to_o, $time);
            end else begin
                e = expQ.pop_front();
                checkOutput("cnt_to", int'(measIf.cnt_to_o), e.cnt);
                checkOutput("locked_with_meas", int'(measIf.locked_o), int'(e.lock));
            end
        end
    end

    initial begin
        measIf.clk_i = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_cnt_to", int'(measIf.cnt_to_o), 0);
        checkOutput("reset_meas_vld", int'(measIf.meas_vld_o), 0);
        checkOutput("reset_locked", int'(measIf.locked_o), 0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // Period 10: the first edge only arms. Lock arrives with the 6th edge.
        applyStimulus(3, 0, 0, 0);
        repeat (4) applyStimulus(10, 1, 10, 0);
        applyStimulus(10, 1, 10, 1);

        // Jitter within TOL keeps lock. A jump of 3 drops it.
        applyStimulus(10, 1, 10, 1);
        applyStimulus(11, 1, 11, 1);
        applyStimulus(9, 1, 9, 1);
        applyStimulus(12, 1, 12, 0);

        // 10 is within TOL of 12, so these count as matches and relock at the 4th.
        repeat (3) applyStimulus(10, 1, 10, 0);
        applyStimulus(10, 1, 10, 1);

        // Period step to 20: unlock at the first sample, relock after 4 matching 20s.
        repeat (4) applyStimulus(20, 1, 20, 0);
        applyStimulus(20, 1, 20, 1);

        // Back to 10, lock, then stop toggling.
        repeat (4) applyStimulus(10, 1, 10, 0);
        applyStimulus(10, 1, 10, 1);
        repeat (200) @(negedge clk);
        checkOutput("locked_before_timeout", int'(measIf.locked_o), 1);
        repeat (100) @(negedge clk);
        checkOutput("locked_after_timeout", int'(measIf.locked_o), 0);
        checkOutput("cnt_to_hold_after_timeout", int'(measIf.cnt_to_o), 10);

        // Timeout returns the block to IDLE, so the next edge only re-arms.
        applyStimulus(5, 0, 0, 0);
        applyStimulus(10, 1, 10, 0);

        // N = 1: meas_vld_o pulses every cycle, and the block still locks.
        repeat (4) applyStimulus(1, 1, 1, 0);
        repeat (3) applyStimulus(1, 1, 1, 1);

        // Relock at 10, then reset halfway through an interval.
        repeat (4) applyStimulus(10, 1, 10, 0);
        applyStimulus(10, 1, 10, 1);
        repeat (5) @(negedge clk);
        checkOutput("locked_before_reset", int'(measIf.locked_o), 1);
        checkOutput("queue_drained_before_reset", expQ.size(), 0);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("async_reset_cnt_to", int'(measIf.cnt_to_o), 0);
        checkOutput("async_reset_meas_vld", int'(measIf.meas_vld_o), 0);
        checkOutput("async_reset_locked", int'(measIf.locked_o), 0);
        measIf.clk_i = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // After release, the first edge arms and the second produces the first measurement.
        applyStimulus(5, 0, 0, 0);
        applyStimulus(10, 1, 10, 0);
        applyStimulus(10, 1, 10, 0);

        repeat (10) @(negedge clk);
        checkOutput("all_expected_meas_seen", expQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/clk_period_meas.md
# clk_period_meas

Measures the half-period of an incoming slow square wave, such as the team's divided clock (toggles every cnt_to cycles of clk), in clk cycles. It recovers the equivalent cnt_to value and reports whether the measurement is stable. It sits on the receive side of the Bluetooth link, where it checks and recovers the link-rate clock before the bit-sampling logic uses it.

## Interface
- CNT_W, 21: width of the interval counter and of cnt_to_o.
- TOL, 2: maximum |difference| in clk cycles between consecutive measurements that still counts as a match.
- LOCK_N, 4: number of consecutive matching pairs required to assert locked_o.
- clk  input  1  system clock; all state is on the rising edge.
- reset  input  1  asynchronous, active-low; clock clk.
- clk_i  input  1  measured waveform, asynchronous to clk.
- cnt_to_o  output  CNT_W  last accepted half-period in clk cycles.
- meas_vld_o  output  1  one-cycle pulse when cnt_to_o is updated.
- locked_o  output  1  measurement stable within TOL.

## Operation
- Synchronizer:
  - clk_i passes through a 2-flop synchronizer (s1, s2) and a history flop s3.
  - edge = s2 ^ s3, so both rising and falling edges of clk_i count.
- Interval counter cnt (CNT_W bits, unsigned):
  - on an edge cycle, cnt <= 1;
  - otherwise cnt <= cnt+1, saturating at 2^CNT_W-1.
  - Edges exactly N cycles apart therefore sample cnt == N. Minimum legal N is 1.
- State machine:
  - IDLE: no edge seen yet. On the first edge go to ARMED; no measurement is produced.
  - ARMED: counting the first interval. On the next edge, accept the measurement and go to TRACK. match_cnt = 0 because there is no predecessor.
  - TRACK: on each edge, accept the measurement and compare it with the previous one.
    - If |new - prev| <= TOL, match_cnt++ (saturates at LOCK_N); otherwise match_cnt = 0.
    - When match_cnt reaches LOCK_N, go to LOCKED.
  - LOCKED: same accept/compare as TRACK. On a mismatch, match_cnt = 0 and go to TRACK.
  - Any state except IDLE: if cnt saturates (2^CNT_W-1) with no edge, this is a timeout. Go to IDLE, clear match_cnt, and drive locked_o to 0. cnt_to_o holds its last value.
- Accepting a measurement:
  - cnt_to_o <= cnt, prev <= cnt, and meas_vld_o pulses for 1 cycle.
- Arithmetic:
  - The difference is computed in CNT_W+1 bits and its absolute value is taken. There is no wrap.
  - The comparison is inclusive of TOL.
- locked_o = (state == LOCKED). It is registered and updates in the same cycle as the meas_vld_o pulse that causes the transition.
- Simultaneous events: an edge in the same cycle that cnt reaches saturation counts as an edge, and the timeout is not taken. The accepted value is 2^CNT_W-1.
- Reset (asynchronous):
  - all outputs go to 0: cnt_to_o = 0, meas_vld_o = 0, locked_o = 0;
  - s1 = s2 = s3 = 0, cnt = 0, match_cnt = 0, state = IDLE.
  - A reset in the middle of a measurement discards the partial interval.
  - After reset, a clk_i that is already high produces an edge, which counts as the first edge (IDLE to ARMED).

## Timing
- A clk_i transition that meets setup at rising clk edge k is captured in s1 at k. The edge is detected in the cycle after k+1.
- meas_vld_o, cnt_to_o and locked_o update at rising edge k+2. They are visible in cycle k+2 to k+3.
- Latency from the clk_i transition to the outputs: 3 clk edges, counting the capture edge.
- For truly asynchronous stimulus, the edge position is uncertain by ±1 cycle, so a single measurement can read N±1.
- First measurement: at the 2nd edge of clk_i.
- Earliest lock: at the (LOCK_N+2)th edge of clk_i.
- meas_vld_o is never high for 2 consecutive cycles unless N = 1.

## Test plan
- Reset, then drive clk_i synchronously, toggling every 10 cycles:
  - no meas_vld_o on edge 1;
  - cnt_to_o = 10 with a meas_vld_o pulse on edge 2;
  - locked_o rises together with the measurement from edge 6 (LOCK_N = 4).
- While locked, intervals 10, 11, 9, 12 (TOL = 2):
  - 11 and 9 keep the lock;
  - 12 differs from 9 by 3, so locked_o drops in that meas_vld_o cycle and cnt_to_o = 12.
- Period step from 10 to 20: locked_o drops at the first 20. It reasserts after 4 further matching intervals of 20.
- CNT_W = 8, locked, then clk_i held constant:
  - after 255 cycles without an edge, locked_o = 0 and the state is IDLE;
  - cnt_to_o holds 10;
  - the next edge produces no meas_vld_o.
- clk_i toggling every cycle: cnt_to_o = 1 and meas_vld_o is high continuously after the 2nd edge. It locks.
- Assert reset halfway through a 10-cycle interval while locked:
  - all outputs are 0 immediately, without waiting for a clk edge;
  - after release, the first measurement is taken on the 2nd edge after release.
